// File: rtl/operand_loader_pkg.sv
// operand_loader shared constants and types.
// Field indices map pushbuttons onto operand nibbles.
package operand_loader_pkg;

  localparam int FLD_A_LO = 0;
  localparam int FLD_A_HI = 1;
  localparam int FLD_B_LO = 2;
  localparam int FLD_B_HI = 3;

  localparam int N_FLD = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W = 18;

  typedef logic [6:0] operand_t;
  typedef logic [3:0] nibble_t;
  typedef logic [N_FLD-1:0] fld_vec_t;

  function automatic operand_t put_lo(
    input operand_t op,
    input nibble_t  d
  );
    operand_t r;
    r = op;
    r[3:0] = d;
    return r;
  endfunction

  function automatic operand_t put_hi(
    input operand_t op,
    input nibble_t  d
  );
    operand_t r;
    r = op;
    r[6:4] = d[2:0];
    return r;
  endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Switch/button bus into operand_loader and the
// registered operand bundle it drives downstream.
interface operand_loader_if;
  import operand_loader_pkg::*;

  fld_vec_t PB;
  nibble_t  Y;
  operand_t A;
  operand_t B;
  fld_vec_t loaded;
  logic     valid;
  logic     load_pulse;
  fld_vec_t db;

  modport master (
    output PB,
    output Y,
    input  A,
    input  B,
    input  loaded,
    input  valid,
    input  load_pulse,
    input  db
  );

  modport slave (
    input  PB,
    input  Y,
    output A,
    output B,
    output loaded,
    output valid,
    output load_pulse,
    output db
  );

endinterface

// File: rtl/operand_loader_pb_debounce.sv
// Per-button synchronizer, debounce counter and
// rising-edge detect aligned with the level toggle.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_term;

  assign w_diff = r_sync ^ r_db;
  assign w_term = w_diff && (r_cnt == TERM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
    end
  end

  // Terminal count toggles and clears in one edge,
  // so the counter never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (w_term) begin
      r_db  <= ~r_db;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign level = r_db;
  assign rise  = w_term & ~r_db;

endmodule

// File: rtl/operand_loader.sv
// Operand capture stage: debounced buttons load
// switch nibbles into registered A/B fields.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  operand_loader_if.slave bus
);

  fld_vec_t w_rise;
  fld_vec_t w_db;

  nibble_t  r_y_meta;
  nibble_t  r_y_s;
  operand_t r_a;
  operand_t r_b;
  fld_vec_t r_loaded;
  logic     r_load_pulse;

  for (genvar g = 0; g < N_FLD; g++) begin : g_pb
    pb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_pb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (bus.PB[g]),
      .level(w_db[g]),
      .rise (w_rise[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_meta <= '0;
      r_y_s    <= '0;
    end else begin
      r_y_meta <= bus.Y;
      r_y_s    <= r_y_meta;
    end
  end

  // No priority: every rising field takes y_s.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_rise[FLD_A_LO] && w_rise[FLD_A_HI])
        r_a <= put_hi(put_lo(r_a, r_y_s), r_y_s);
      else if (w_rise[FLD_A_LO])
        r_a <= put_lo(r_a, r_y_s);
      else if (w_rise[FLD_A_HI])
        r_a <= put_hi(r_a, r_y_s);

      if (w_rise[FLD_B_LO] && w_rise[FLD_B_HI])
        r_b <= put_hi(put_lo(r_b, r_y_s), r_y_s);
      else if (w_rise[FLD_B_LO])
        r_b <= put_lo(r_b, r_y_s);
      else if (w_rise[FLD_B_HI])
        r_b <= put_hi(r_b, r_y_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_loaded     <= '0;
      r_load_pulse <= 1'b0;
    end else begin
      r_loaded     <= r_loaded | w_rise;
      r_load_pulse <= |w_rise;
    end
  end

  assign bus.A          = r_a;
  assign bus.B          = r_b;
  assign bus.loaded     = r_loaded;
  assign bus.valid      = &r_loaded;
  assign bus.load_pulse = r_load_pulse;
  assign bus.db         = w_db;

endmodule
